// File: rtl/vsa_mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the VSA fetch port and
// data port; one access at a time, ties granted round-robin.
module vsa_mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 12,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with stable addr/we/wdata and holds it
  // until its one-cycle ack; req may drop or carry a new request at the edge
  // that ends the ack cycle. Inputs are sampled only in IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          win;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // gnt/last_grant encoding: 0 = fetch port, 1 = data port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    win        = (if_req && d_req) ? ~last_q : d_req;
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_ISSUE;
          last_d  = win;
          gnt_d   = win;
          addr_d  = win ? d_addr : if_addr;
          we_d    = win & d_we;
          if (win) wdata_d = d_wdata;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = LAT_M1;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (gnt_q) d_rdata_d = mem_rdata;
            else       if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    if_ack    = (state_q == S_RESP) && !gnt_q;
    d_ack     = (state_q == S_RESP) && gnt_q;
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_vsa_mem_arbiter.sv
// Bench for vsa_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_vsa_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req[2];
  logic [4:0]  if_addr[2];
  logic        if_ack[2];
  logic [11:0] if_rdata[2];
  logic        d_req[2];
  logic        d_we[2];
  logic [4:0]  d_addr[2];
  logic [11:0] d_wdata[2];
  logic        d_ack[2];
  logic [11:0] d_rdata[2];
  logic        mem_en[2];
  logic        mem_we[2];
  logic [4:0]  mem_addr[2];
  logic [11:0] mem_wdata[2];
  logic [11:0] mem_rdata[2];
  logic        busy[2];
  logic [1:0]  dbg_state[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // environment memory (answers the DUT) and model memory (predicts results)
  logic [11:0] env_mem[2][32];
  logic [11:0] ref_mem[2][32];
  logic        rd_pend[2];
  int          rd_due[2];
  logic [11:0] rd_val[2];

  // transaction-level model state
  logic        m_act[2];
  int          m_start[2];
  logic        m_port[2];
  logic        m_last[2];
  logic [4:0]  m_addr[2];
  logic        m_we[2];
  logic [11:0] m_wd[2];
  logic [4:0]  m_ah[2];
  logic [11:0] m_wh[2];
  logic [11:0] m_ifr[2];
  logic [11:0] m_dr[2];
  logic        ack_if[2];
  logic        ack_d[2];

  vsa_mem_arbiter #(.AW(5), .DW(12), .MEM_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  vsa_mem_arbiter #(.AW(5), .DW(12), .MEM_LAT(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
    end
  endtask

  // Runs at the negedge of every cycle: memory environment, model, compare.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   off;
      int   lat;
      logic e_busy, e_en, e_we, e_ia, e_da;
      lat = (k == 0) ? 1 : 3;
      if (rd_pend[k] && cyc == rd_due[k]) begin
        mem_rdata[k] = rd_val[k];
        rd_pend[k] = 1'b0;
      end else begin
        mem_rdata[k] = 12'($urandom);
      end
      if (!reset && mem_en[k]) begin
        if (mem_we[k]) env_mem[k][mem_addr[k]] = mem_wdata[k];
        else begin
          rd_pend[k] = 1'b1;
          rd_due[k]  = cyc + lat;
          rd_val[k]  = env_mem[k][mem_addr[k]];
        end
      end
      off = 0; e_busy = 0; e_en = 0; e_we = 0; e_ia = 0; e_da = 0;
      if (reset) begin
        m_act[k] = 0; m_last[k] = 1; m_ah[k] = '0; m_wh[k] = '0; m_ifr[k] = '0; m_dr[k] = '0;
      end else if (m_act[k]) begin
        off = cyc - m_start[k];
        e_busy = 1;
        if (off == 1) begin
          e_en = 1;
          e_we = m_we[k];
          m_ah[k] = m_addr[k];
          if (m_port[k]) m_wh[k] = m_wd[k];
        end
        if (off == 2 + lat) begin
          if (m_port[k]) e_da = 1; else e_ia = 1;
          if (m_we[k]) ref_mem[k][m_addr[k]] = m_wd[k];
          else if (m_port[k]) m_dr[k] = ref_mem[k][m_addr[k]];
          else m_ifr[k] = ref_mem[k][m_addr[k]];
        end
      end
      cmp("busy", k, 32'(busy[k]), 32'(e_busy));
      cmp("mem_en", k, 32'(mem_en[k]), 32'(e_en));
      cmp("mem_we", k, 32'(mem_we[k]), 32'(e_we));
      cmp("mem_addr", k, 32'(mem_addr[k]), 32'(m_ah[k]));
      cmp("if_ack", k, 32'(if_ack[k]), 32'(e_ia));
      cmp("d_ack", k, 32'(d_ack[k]), 32'(e_da));
      cmp("if_rdata", k, 32'(if_rdata[k]), 32'(m_ifr[k]));
      cmp("d_rdata", k, 32'(d_rdata[k]), 32'(m_dr[k]));
      if (reset || e_we) cmp("mem_wdata", k, 32'(mem_wdata[k]), 32'(m_wh[k]));
      if (!reset) begin
        if (m_act[k] && off == 2 + lat) begin
          m_act[k] = 0;
          if (m_port[k]) ack_d[k] = 1; else ack_if[k] = 1;
        end else if (!m_act[k] && (if_req[k] || d_req[k])) begin
          m_port[k]  = (if_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
          m_last[k]  = m_port[k];
          m_act[k]   = 1;
          m_start[k] = cyc;
          m_addr[k]  = m_port[k] ? d_addr[k] : if_addr[k];
          m_we[k]    = m_port[k] && d_we[k];
          m_wd[k]    = d_wdata[k];
        end
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
    model_step();
  endtask

  task automatic to_pos();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
      if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  task automatic agents();
    for (int k = 0; k < 2; k++) begin
      if (!if_req[k]) begin
        if ($urandom_range(0, 2) != 0) begin
          if_req[k] = 1; if_addr[k] = 5'($urandom_range(0, 11));
        end
      end else if (ack_if[k]) begin
        if ($urandom_range(0, 1) == 0) if_req[k] = 0;
        else if_addr[k] = 5'($urandom_range(0, 11));
      end
      ack_if[k] = 0;
      if (!d_req[k]) begin
        if ($urandom_range(0, 2) != 0) begin
          d_req[k] = 1; d_we[k] = 1'($urandom); d_addr[k] = 5'($urandom_range(0, 11));
          d_wdata[k] = 12'($urandom);
        end
      end else if (ack_d[k]) begin
        if ($urandom_range(0, 1) == 0) d_req[k] = 0;
        else begin
          d_we[k] = 1'($urandom); d_addr[k] = 5'($urandom_range(0, 11));
          d_wdata[k] = 12'($urandom);
        end
      end
      ack_d[k] = 0;
    end
  endtask

  initial begin
    logic [11:0] v;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) begin
        v = 12'($urandom);
        env_mem[k][a] = v;
        ref_mem[k][a] = v;
      end
      env_mem[k][4] = 12'hA5C; ref_mem[k][4] = 12'hA5C;
      env_mem[k][16] = 12'h3C7; ref_mem[k][16] = 12'h3C7;
      rd_pend[k] = 0; rd_due[k] = 0; rd_val[k] = '0; mem_rdata[k] = '0;
      m_act[k] = 0; m_last[k] = 1; ack_if[k] = 0; ack_d[k] = 0;
    end
    idle_all();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      cmp("rst_busy", 0, 32'(busy[0]), 32'd0);
      to_pos();
    end
    reset = 0;

    // single fetch on both latencies
    for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 5'h04; end
    for (int i = 0; i <= 5; i++) begin
      to_neg();
      cmp("fetch_busy", 0, 32'(busy[0]), 32'(i >= 1 && i <= 3));
      cmp("fetch_en", 0, 32'(mem_en[0]), 32'(i == 1));
      cmp("fetch_ack", 0, 32'(if_ack[0]), 32'(i == 3));
      cmp("lat3_en", 1, 32'(mem_en[1]), 32'(i == 1));
      cmp("lat3_ack", 1, 32'(if_ack[1]), 32'(i == 5));
      if (i == 1) cmp("fetch_addr", 0, 32'(mem_addr[0]), 32'h04);
      if (i == 3 || i == 4) cmp("fetch_rdata", 0, 32'(if_rdata[0]), 32'hA5C);
      if (i == 4) cmp("lat3_pre", 1, 32'(if_rdata[1]), 32'h0);
      if (i == 5) cmp("lat3_rdata", 1, 32'(if_rdata[1]), 32'hA5C);
      to_pos();
      if (i == 3) if_req[0] = 0;
      if (i == 5) if_req[1] = 0;
    end

    // tie after reset: fetch first, then data
    reset = 1; to_neg(); to_pos(); reset = 0;
    if_req[0] = 1; d_req[0] = 1; if_addr[0] = 5'h02; d_addr[0] = 5'h10; d_we[0] = 0;
    for (int i = 0; i <= 7; i++) begin
      to_neg();
      cmp("tie_ifack", 0, 32'(if_ack[0]), 32'(i == 3));
      cmp("tie_dack", 0, 32'(d_ack[0]), 32'(i == 7));
      if (i == 1) cmp("tie_addr1", 0, 32'(mem_addr[0]), 32'h02);
      if (i == 5) cmp("tie_addr2", 0, 32'(mem_addr[0]), 32'h10);
      if (i == 5) cmp("tie_en2", 0, 32'(mem_en[0]), 32'd1);
      if (i == 7) cmp("tie_drdata", 0, 32'(d_rdata[0]), 32'h3C7);
      to_pos();
      if (i == 3) if_req[0] = 0;
      if (i == 7) d_req[0] = 0;
    end

    // data write
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 5'h1F; d_wdata[0] = 12'h013;
    for (int i = 0; i <= 3; i++) begin
      to_neg();
      cmp("wr_en", 0, 32'(mem_en[0]), 32'(i == 1));
      cmp("wr_we", 0, 32'(mem_we[0]), 32'(i == 1));
      cmp("wr_dack", 0, 32'(d_ack[0]), 32'(i == 3));
      cmp("wr_ifack", 0, 32'(if_ack[0]), 32'd0);
      if (i == 1) cmp("wr_wdata", 0, 32'(mem_wdata[0]), 32'h013);
      if (i == 1) cmp("wr_addr", 0, 32'(mem_addr[0]), 32'h1F);
      if (i == 3) cmp("wr_drdata", 0, 32'(d_rdata[0]), 32'h3C7);
      to_pos();
    end
    d_req[0] = 0; d_we[0] = 0;

    // both held: strict alternation, last grant was data so fetch leads
    if_req[0] = 1; d_req[0] = 1; if_addr[0] = 5'h02; d_addr[0] = 5'h10;
    for (int i = 0; i < 32; i++) begin
      to_neg();
      cmp("alt_ifack", 0, 32'(if_ack[0]), 32'(i % 4 == 3 && (i / 4) % 2 == 0));
      cmp("alt_dack", 0, 32'(d_ack[0]), 32'(i % 4 == 3 && (i / 4) % 2 == 1));
      to_pos();
    end
    if_req[0] = 0; d_req[0] = 0;

    // reset during WAIT of a data read, request kept high
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 5'h10;
    for (int i = 0; i <= 6; i++) begin
      if (i == 2) reset = 1;
      if (i == 3) reset = 0;
      to_neg();
      cmp("rst_dack", 0, 32'(d_ack[0]), 32'(i == 6));
      cmp("rst_en", 0, 32'(mem_en[0]), 32'(i == 1 || i == 4));
      if (i == 2) begin
        cmp("rst_busy0", 0, 32'(busy[0]), 32'd0);
        cmp("rst_maddr", 0, 32'(mem_addr[0]), 32'd0);
        cmp("rst_mwdata", 0, 32'(mem_wdata[0]), 32'd0);
        cmp("rst_drdata", 0, 32'(d_rdata[0]), 32'd0);
        cmp("rst_ifrdata", 0, 32'(if_rdata[0]), 32'd0);
      end
      if (i == 6) cmp("rst_reread", 0, 32'(d_rdata[0]), 32'h3C7);
      to_pos();
    end
    d_req[0] = 0;

    // randomized traffic with occasional resets
    for (int k = 0; k < 2; k++) begin ack_if[k] = 0; ack_d[k] = 0; end
    for (int i = 0; i < 2000; i++) begin
      to_neg();
      to_pos();
      if (reset) reset = 0;
      else if ($urandom_range(0, 299) == 0) reset = 1;
      agents();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
